// File: rtl/fas_frame_sched.sv
// Packs FIR samples into 16-sample frames across two ping-pong banks and
// launches the FFT engine once per full frame, serving its reads from the launched bank.
module fas_frame_sched #(
  parameter int DW         = 16,
  parameter int NUM_FRAMES = 64,
  parameter int CW         = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fir_valid,
  input  logic [DW-1:0] fir_d,
  output logic          fft_start,
  output logic          fft_bank,
  input  logic [3:0]    fft_raddr,
  output logic [DW-1:0] fft_rdata,
  input  logic          fft_done,
  output logic          eng_busy,
  output logic [CW-1:0] frame_cnt,
  output logic          all_done,
  output logic          overflow,
  output logic [1:0]    dbg_state
);

  // Handshake: fir_valid is a strobe with no back-pressure; a sample is taken
  // on any edge where it is high and the target bank can take it, otherwise
  // it is dropped and flagged. fft_start/fft_done frame one engine run.
  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DONE} state_t;

  state_t          r_state;
  logic [DW-1:0]   r_mem [2][16];
  logic [1:0]      r_full;
  logic            r_wr_bank;
  logic            r_rd_bank;
  logic [3:0]      r_wr_cnt;
  logic            r_fft_start;
  logic            r_eng_busy;
  logic            r_all_done;
  logic            r_overflow;
  logic [CW-1:0]   r_frame_cnt;

  logic            w_release;
  logic            w_free_now;
  logic            w_accept;
  logic            w_drop;
  logic            w_frame_end;
  logic [1:0]      w_full_nxt;
  logic [CW-1:0]   w_cnt_inc;

  assign w_release   = (r_state == S_RUN) && fft_done;
  assign w_free_now  = w_release && (r_rd_bank == r_wr_bank);
  assign w_accept    = fir_valid && !r_all_done && (!r_full[r_wr_bank] || w_free_now);
  assign w_drop      = fir_valid && !r_all_done && !w_accept;
  assign w_frame_end = w_accept && (r_wr_cnt == 4'd15);
  assign w_cnt_inc   = r_frame_cnt + CW'(1);

  // Set is applied after clear so a bank refilled on its release edge stays full.
  always_comb begin
    w_full_nxt = r_full;
    if (w_release)   w_full_nxt[r_rd_bank] = 1'b0;
    if (w_frame_end) w_full_nxt[r_wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int a = 0; a < 16; a++) begin
          r_mem[b][a] <= '0;
        end
      end
      r_full     <= '0;
      r_wr_bank  <= 1'b0;
      r_wr_cnt   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      if (w_accept) begin
        r_mem[r_wr_bank][r_wr_cnt] <= fir_d;
        r_wr_cnt                   <= r_wr_cnt + 4'd1;
        if (w_frame_end) r_wr_bank <= ~r_wr_bank;
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rd_bank   <= 1'b0;
      r_frame_cnt <= '0;
      r_fft_start <= 1'b0;
      r_eng_busy  <= 1'b0;
      r_all_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_full[r_rd_bank]) begin
            r_state     <= S_START;
            r_fft_start <= 1'b1;
            r_eng_busy  <= 1'b1;
          end
        end
        S_START: begin
          r_state     <= S_RUN;
          r_fft_start <= 1'b0;
        end
        S_RUN: begin
          if (fft_done) begin
            r_rd_bank   <= ~r_rd_bank;
            r_frame_cnt <= w_cnt_inc;
            r_eng_busy  <= 1'b0;
            if (w_cnt_inc == CW'(NUM_FRAMES)) begin
              r_state    <= S_DONE;
              r_all_done <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_DONE:  r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign fft_start = r_fft_start;
  assign fft_bank  = r_rd_bank;
  assign fft_rdata = r_mem[r_rd_bank][fft_raddr];
  assign eng_busy  = r_eng_busy;
  assign frame_cnt = r_frame_cnt;
  assign all_done  = r_all_done;
  assign overflow  = r_overflow;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fas_frame_sched.sv
// Random-stimulus bench for fas_frame_sched: a frame-level reference model feeds
// an expected queue that a start monitor drains while reading back each frame.
module tb_fas_frame_sched;
  localparam int DW         = 16;
  localparam int NUM_FRAMES = 64;
  localparam int CW         = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          fir_valid;
  logic [DW-1:0] fir_d;
  logic          fft_start;
  logic          fft_bank;
  logic [3:0]    fft_raddr;
  logic [DW-1:0] fft_rdata;
  logic          fft_done;
  logic          eng_busy;
  logic [CW-1:0] frame_cnt;
  logic          all_done;
  logic          overflow;
  logic [1:0]    dbg_state;

  fas_frame_sched #(.DW(DW), .NUM_FRAMES(NUM_FRAMES), .CW(CW)) dut (
    .clk(clk), .rst(rst), .fir_valid(fir_valid), .fir_d(fir_d),
    .fft_start(fft_start), .fft_bank(fft_bank), .fft_raddr(fft_raddr),
    .fft_rdata(fft_rdata), .fft_done(fft_done), .eng_busy(eng_busy),
    .frame_cnt(frame_cnt), .all_done(all_done), .overflow(overflow),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  logic          exp_bank_q[$];
  int            exp_cyc_q[$];

  int checks = 0, errors = 0;
  int mon_checks = 0, mon_errors = 0;
  int starts = 0;

  // Reference model: frames as whole units; at most two complete frames may be
  // held, and a release on the same edge makes room for a further sample.
  logic [DW-1:0] m_cur[$];
  int            m_full;
  int            m_frame_cnt;
  logic          m_overflow;
  logic          m_all_done;
  logic          m_bank;

  logic eng_active;
  int   eng_cd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mchk(input string name, input logic [31:0] act, input logic [31:0] exp);
    mon_checks++;
    if (act !== exp) begin
      mon_errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_cur.delete();
    exp_q.delete();
    exp_bank_q.delete();
    exp_cyc_q.delete();
    m_full      = 0;
    m_frame_cnt = 0;
    m_overflow  = 1'b0;
    m_all_done  = 1'b0;
    m_bank      = 1'b0;
    eng_active  = 1'b0;
    eng_cd      = 0;
    starts      = 0;
  endtask

  task automatic model_step(input logic v, input logic [DW-1:0] d, input logic dn);
    logic acc;
    acc = v && !m_all_done && (m_full < 2 || dn);
    if (v && !m_all_done && !acc) m_overflow = 1'b1;
    if (dn) begin
      m_full--;
      m_frame_cnt++;
      if (m_frame_cnt == NUM_FRAMES) m_all_done = 1'b1;
    end
    if (acc) begin
      m_cur.push_back(d);
      if (m_cur.size() == 16) begin
        foreach (m_cur[i]) exp_q.push_back(m_cur[i]);
        exp_bank_q.push_back(m_bank);
        // A lone full frame must launch exactly one cycle after its last sample.
        exp_cyc_q.push_back(m_full == 0 ? cyc + 2 : -1);
        m_full++;
        m_bank = ~m_bank;
        m_cur.delete();
      end
    end
  endtask

  // ---------------- driver: one cycle of stimulus + engine ----------------
  task automatic step_cycle(input int pv, input int lat_lo, input int lat_hi);
    logic          v;
    logic [DW-1:0] d;
    logic          dn;
    @(negedge clk);
    dn = 1'b0;
    if (eng_active) begin
      eng_cd--;
      if (eng_cd == 0) dn = 1'b1;
    end
    if (fft_start) begin
      eng_active = 1'b1;
      eng_cd     = $urandom_range(lat_hi, lat_lo);
    end
    chk("eng_busy", eng_busy, eng_active);
    chk("frame_cnt", frame_cnt, m_frame_cnt);
    chk("overflow", overflow, m_overflow);
    chk("all_done", all_done, m_all_done);
    v = ($urandom_range(99, 0) < pv);
    d = DW'($urandom);
    fir_valid = v;
    fir_d     = d;
    fft_done  = dn;
    model_step(v, d, dn);
    if (dn) eng_active = 1'b0;
  endtask

  // ---------------- monitor: checks each launch and reads the frame ----------------
  initial begin
    logic exp_b;
    int   exp_c;
    fft_raddr = 4'd0;
    forever begin
      @(negedge clk);
      if (!rst && fft_start) begin
        starts++;
        if (exp_bank_q.size() == 0) begin
          mon_checks++;
          mon_errors++;
          $display("FAIL unexpected_start actual=1 expected=0 (cycle %0d)", cyc);
        end else begin
          exp_b = exp_bank_q.pop_front();
          exp_c = exp_cyc_q.pop_front();
          mchk("fft_bank", fft_bank, exp_b);
          if (exp_c >= 0) mchk("start_latency", cyc, exp_c);
          for (int a = 0; a < 16; a++) begin
            fft_raddr = a[3:0];
            #1;
            mchk("fft_rdata", fft_rdata, exp_q.pop_front());
          end
          fft_raddr = 4'd0;
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int  n;
    bit  hit;
    rst       = 1'b1;
    fir_valid = 1'b0;
    fir_d     = '0;
    fft_done  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_fft_start", fft_start, 1'b0);
    chk("rst_fft_bank", fft_bank, 1'b0);
    chk("rst_eng_busy", eng_busy, 1'b0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_all_done", all_done, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_state", dbg_state, 2'd0);
    chk("rst_rdata", fft_rdata, 0);

    // Phase 1: random traffic with slow engine runs, then reset mid-run.
    hit = 1'b0;
    for (n = 0; n < 4000 && !hit; n++) begin
      step_cycle(90, 1, 24);
      hit = (m_frame_cnt >= 3) && eng_active && (m_cur.size() > 0);
    end
    if (!hit) begin
      errors++;
      checks++;
      $display("FAIL phase1_timeout actual=%0d expected=3 frames (cycle %0d)", m_frame_cnt, cyc);
    end
    @(posedge clk);
    #10;
    rst = 1'b1;
    #1;
    chk("arst_fft_start", fft_start, 1'b0);
    chk("arst_fft_bank", fft_bank, 1'b0);
    chk("arst_eng_busy", eng_busy, 1'b0);
    chk("arst_frame_cnt", frame_cnt, 0);
    chk("arst_all_done", all_done, 1'b0);
    chk("arst_overflow", overflow, 1'b0);
    fir_valid = 1'b0;
    fft_done  = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Phase 2a: sustained full-rate input with short engine runs never drops.
    for (int i = 0; i < 300; i++) step_cycle(100, 1, 14);
    chk("sustained_no_drop", overflow, 1'b0);

    // Phase 2b: mixed rates and long engine runs until the run completes.
    for (n = 0; n < 20000 && !m_all_done; n++) begin
      step_cycle($urandom_range(100, 60), 1, 30);
    end
    if (!m_all_done) begin
      errors++;
      checks++;
      $display("FAIL run_timeout actual=%0d expected=%0d frames (cycle %0d)", m_frame_cnt, NUM_FRAMES, cyc);
    end

    // Input after end-of-run is ignored and never flags overflow.
    for (int i = 0; i < 40; i++) step_cycle(100, 1, 30);
    chk("final_frame_cnt", frame_cnt, NUM_FRAMES);
    chk("final_all_done", all_done, 1'b1);
    chk("final_overflow_model", overflow, m_overflow);
    chk("starts_in_run", starts, NUM_FRAMES);

    checks = checks + mon_checks;
    errors = errors + mon_errors;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
